// File: rtl/bus_tx_queue.sv
// ---------------------------------------------------------------------------
// bus_tx_queue
//
// Device-side transmit stage in front of a shared tri-state bus. Words from
// the local device are buffered in a small FIFO; while words are queued the
// block requests the bus, and it pops one word on every granted cycle. The
// head word is always presented on bus_data for the tri-state driver.
//
// Optional feature macro: BUS_TX_BURST_LIMIT_EN
//   defined   : after MAX_BURST consecutive pops the queue drops req for one
//               cycle (YIELD) so the other device can win arbitration.
//   undefined : req is held until the FIFO drains or grant is removed;
//               MAX_BURST has no effect.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   wr_data   word from the local device
//   wr_en     push wr_data this cycle
//   full      FIFO holds DEPTH words
//   empty     FIFO holds no words
//   count     current occupancy
//   overflow  sticky flag: a push was dropped because the FIFO was full
//   req       registered bus request to the arbiter
//   grant     grant from the arbiter for this device
//   bus_data  head word (zero when empty)
//   sent      one-cycle pulse in the cycle after each pop
// ---------------------------------------------------------------------------
module bus_tx_queue #(
    parameter int N         = 8,
    parameter int DEPTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               wr_data,
    input  logic                       wr_en,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       req,
    input  logic                       grant,
    output logic [N-1:0]               bus_data,
    output logic                       sent
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Elaboration-time parameter sanity check.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_BURST < 1) begin : g_bad_params
        $error("bus_tx_queue: DEPTH must be a power of 2 >= 2 and MAX_BURST >= 1");
    end

`ifdef BUS_TX_BURST_LIMIT_EN
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
    typedef enum logic [1:0] {IDLE, REQ, XFER, YIELD} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
`endif

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          overflow_reg;
    logic          sent_reg;
    logic          req_reg;
    state_t        state_reg;
`ifdef BUS_TX_BURST_LIMIT_EN
    logic [BW-1:0] burst_cnt_reg;
`endif

    logic push;
    logic pop;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign req      = req_reg;
    assign sent     = sent_reg;
    assign bus_data = empty ? '0 : mem[rd_ptr_reg];

    // Grants are honoured only while we are actually requesting.
    assign pop  = ((state_reg == REQ) || (state_reg == XFER)) && grant && !empty;
    // A full FIFO still accepts a word if the head leaves on the same edge.
    assign push = wr_en && (!full || pop);

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Storage carries no reset: an empty FIFO masks bus_data, so stale
    // contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers, occupancy and status flags. Pointers wrap naturally since
    // DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            sent_reg     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (wr_en && !push) begin
                overflow_reg <= 1'b1;
            end
            count_reg <= count_next;
            sent_reg  <= pop;
        end
    end

    // Request state machine; req is registered alongside the state so that
    // it is 1 exactly in REQ and XFER.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            req_reg       <= 1'b0;
`ifdef BUS_TX_BURST_LIMIT_EN
            burst_cnt_reg <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    // Uses the registered count, giving two edges from push to req.
                    if (count_reg != '0) begin
                        state_reg <= REQ;
                        req_reg   <= 1'b1;
                    end
                end
                REQ: begin
                    if (empty) begin
                        state_reg <= IDLE;
                        req_reg   <= 1'b0;
                    end else if (grant) begin
                        if (count_next == '0) begin
                            state_reg <= IDLE;
                            req_reg   <= 1'b0;
`ifdef BUS_TX_BURST_LIMIT_EN
                            burst_cnt_reg <= '0;
                        end else if (BW'(MAX_BURST) == BW'(1)) begin
                            state_reg     <= YIELD;
                            req_reg       <= 1'b0;
                            burst_cnt_reg <= BW'(1);
`endif
                        end else begin
                            state_reg <= XFER;
                            req_reg   <= 1'b1;
`ifdef BUS_TX_BURST_LIMIT_EN
                            burst_cnt_reg <= BW'(1);
`endif
                        end
                    end
                end
                XFER: begin
                    if (empty) begin
                        state_reg <= IDLE;
                        req_reg   <= 1'b0;
`ifdef BUS_TX_BURST_LIMIT_EN
                        burst_cnt_reg <= '0;
`endif
                    end else if (grant) begin
                        // Draining takes priority over yielding.
                        if (count_next == '0) begin
                            state_reg <= IDLE;
                            req_reg   <= 1'b0;
`ifdef BUS_TX_BURST_LIMIT_EN
                            burst_cnt_reg <= '0;
                        end else if (burst_cnt_reg + BW'(1) == BW'(MAX_BURST)) begin
                            state_reg     <= YIELD;
                            req_reg       <= 1'b0;
                            burst_cnt_reg <= burst_cnt_reg + BW'(1);
                        end else begin
                            burst_cnt_reg <= burst_cnt_reg + BW'(1);
`endif
                        end
                    end else begin
                        // Pre-empted: keep requesting, new tenure starts fresh.
                        state_reg <= REQ;
                        req_reg   <= 1'b1;
`ifdef BUS_TX_BURST_LIMIT_EN
                        burst_cnt_reg <= '0;
`endif
                    end
                end
`ifdef BUS_TX_BURST_LIMIT_EN
                YIELD: begin
                    burst_cnt_reg <= '0;
                    if (count_next != '0) begin
                        state_reg <= REQ;
                        req_reg   <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        req_reg   <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_tx_queue.sv
// ---------------------------------------------------------------------------
// tb_bus_tx_queue
//
// Directed bench for bus_tx_queue (N=8, DEPTH=4, MAX_BURST=2). A table of
// per-cycle vectors covers basic transfer, ignored grant, fill/overflow,
// push+pop while full and at count=1, and pre-emption. Hand-written
// sequences cover asynchronous reset mid-burst, the burst limit (expected
// values depend on BUS_TX_BURST_LIMIT_EN) and pre-emption ordering.
// Inputs change 1ns after the rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_bus_tx_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       req;
    logic       grant;
    logic [7:0] bus_data;
    logic       sent;

    int checks = 0;
    int errors = 0;

    bus_tx_queue #(.N(8), .DEPTH(4), .MAX_BURST(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .req      (req),
        .grant    (grant),
        .bus_data (bus_data),
        .sent     (sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       gnt;
        logic       e_req;
        logic [2:0] e_cnt;
        logic [7:0] e_bus;
        logic       e_sent;
        logic       e_empty;
        logic       e_full;
        logic       e_ovf;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Apply inputs, advance one rising edge, then settle 1ns.
    task automatic step(input logic we, input logic [7:0] wd, input logic gnt);
        wr_en   = we;
        wr_data = wd;
        grant   = gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic e_req, input logic [2:0] e_cnt,
                              input logic [7:0] e_bus, input logic e_sent);
        check({tag, ".req"},      {15'd0, req},      {15'd0, e_req});
        check({tag, ".count"},    {13'd0, count},    {13'd0, e_cnt});
        check({tag, ".bus_data"}, {8'd0, bus_data},  {8'd0, e_bus});
        check({tag, ".sent"},     {15'd0, sent},     {15'd0, e_sent});
        $display("  %s: req=%0b count=%0d bus=%02h sent=%0b", tag, req, count, bus_data, sent);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        wr_en = 1'b0; wr_data = 8'h00; grant = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Burst-limit expectations, indexed by granted edge.
    logic       b_sent [6];
    logic       b_req  [6];
    logic [7:0] b_bus  [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            we  wd     g   req cnt bus    sent emp full ovf
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 3'd1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 3'd2, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 8'h11, 1'b0, 1'b0, 3'd1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'h22, 1'b0, 1'b1, 3'd2, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'h33, 1'b0, 1'b1, 3'd3, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 8'h44, 1'b0, 1'b1, 3'd4, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 8'h55, 1'b0, 1'b1, 3'd4, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 8'h66, 1'b1, 1'b1, 3'd4, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd2, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[19] = '{1'b1, 8'h77, 1'b1, 1'b1, 3'd1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};

        // ---------------- reset state ----------------
        do_reset();
        check("rst.req",      {15'd0, req},      16'd0);
        check("rst.count",    {13'd0, count},    16'd0);
        check("rst.empty",    {15'd0, empty},    16'd1);
        check("rst.full",     {15'd0, full},     16'd0);
        check("rst.overflow", {15'd0, overflow}, 16'd0);
        check("rst.sent",     {15'd0, sent},     16'd0);
        check("rst.bus_data", {8'd0, bus_data},  16'd0);
        $display("reset: req=%0b count=%0d empty=%0b bus=%02h", req, count, empty, bus_data);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 22; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(tbl[i].we, tbl[i].wd, tbl[i].gnt);
            check({tag, ".req"},      {15'd0, req},      {15'd0, tbl[i].e_req});
            check({tag, ".count"},    {13'd0, count},    {13'd0, tbl[i].e_cnt});
            check({tag, ".bus_data"}, {8'd0, bus_data},  {8'd0, tbl[i].e_bus});
            check({tag, ".sent"},     {15'd0, sent},     {15'd0, tbl[i].e_sent});
            check({tag, ".empty"},    {15'd0, empty},    {15'd0, tbl[i].e_empty});
            check({tag, ".full"},     {15'd0, full},     {15'd0, tbl[i].e_full});
            check({tag, ".overflow"}, {15'd0, overflow}, {15'd0, tbl[i].e_ovf});
            $display("vec%0d: we=%0b wd=%02h g=%0b -> req=%0b cnt=%0d bus=%02h sent=%0b emp=%0b full=%0b ovf=%0b",
                     i, tbl[i].we, tbl[i].wd, tbl[i].gnt, req, count, bus_data, sent, empty, full, overflow);
        end

        // ---------------- reset mid-burst ----------------
        step(1'b1, 8'hC1, 1'b0);
        step(1'b1, 8'hC2, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        check_outs("mid.pre", 1'b1, 3'd3, 8'hC1, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check_outs("mid.pop", 1'b1, 3'd2, 8'hC2, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("mid.rst.req",      {15'd0, req},      16'd0);
        check("mid.rst.count",    {13'd0, count},    16'd0);
        check("mid.rst.empty",    {15'd0, empty},    16'd1);
        check("mid.rst.bus_data", {8'd0, bus_data},  16'd0);
        check("mid.rst.overflow", {15'd0, overflow}, 16'd0);
        check("mid.rst.sent",     {15'd0, sent},     16'd0);
        $display("mid-reset: req=%0b count=%0d empty=%0b bus=%02h ovf=%0b", req, count, empty, bus_data, overflow);
        grant = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // ---------------- burst limit ----------------
`ifdef BUS_TX_BURST_LIMIT_EN
        b_sent = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        b_req  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        b_bus  = '{8'hD1, 8'hD2, 8'hD2, 8'hD3, 8'h00, 8'h00};
`else
        b_sent = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        b_req  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        b_bus  = '{8'hD1, 8'hD2, 8'hD3, 8'h00, 8'h00, 8'h00};
`endif
        step(1'b1, 8'hD0, 1'b0);
        step(1'b1, 8'hD1, 1'b0);
        step(1'b1, 8'hD2, 1'b0);
        step(1'b1, 8'hD3, 1'b0);
        check("burst.pre.req",  {15'd0, req},  16'd1);
        check("burst.pre.full", {15'd0, full}, 16'd1);
        for (int k = 0; k < 6; k++) begin
            string tag;
            tag = $sformatf("burst%0d", k);
            step(1'b0, 8'h00, 1'b1);
            check({tag, ".sent"},     {15'd0, sent},    {15'd0, b_sent[k]});
            check({tag, ".req"},      {15'd0, req},     {15'd0, b_req[k]});
            check({tag, ".bus_data"}, {8'd0, bus_data}, {8'd0, b_bus[k]});
            $display("burst%0d: req=%0b sent=%0b bus=%02h count=%0d", k, req, sent, bus_data, count);
        end
        check("burst.empty", {15'd0, empty}, 16'd1);

        // ---------------- pre-emption ----------------
        step(1'b1, 8'hB1, 1'b0);
        step(1'b1, 8'hB2, 1'b0);
        step(1'b1, 8'hB3, 1'b0);
        check_outs("pre.fill", 1'b1, 3'd3, 8'hB1, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check_outs("pre.pop1", 1'b1, 3'd2, 8'hB2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'h00, 1'b0);
            check_outs($sformatf("pre.hold%0d", k), 1'b1, 3'd2, 8'hB2, 1'b0);
        end
        step(1'b0, 8'h00, 1'b1);
        check_outs("pre.pop2", 1'b1, 3'd1, 8'hB3, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check_outs("pre.pop3", 1'b0, 3'd0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check_outs("pre.idle", 1'b0, 3'd0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_tx_queue.md
Name: bus_tx_queue

Overview:
Device-side transmit stage that sits directly upstream of the shared tri-state bus. Buffers words written by a local device in a small FIFO, raises the bus request toward the arbiter, and presents the head word on its bus-data output for the tri-state driver. Pops one word per granted cycle. With the optional feature enabled, it enforces a burst limit so that the other device gets the bus.

Parameters:
N, 8, data word width; matches the bus width.
DEPTH, 4, FIFO entries; must be a power of 2, ≥2.
MAX_BURST, 4, maximum consecutive words per bus tenure; ≥1; used only when BUS_TX_BURST_LIMIT_EN is defined.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset.
wr_data  input  N  word from the local device.
wr_en  input  1  push wr_data this cycle.
full  output  1  FIFO holds DEPTH words.
empty  output  1  FIFO holds 0 words.
count  output  $clog2(DEPTH+1)  current occupancy.
overflow  output  1  sticky; set when a push is dropped.
req  output  1  bus request to the arbiter; registered and glitch-free.
grant  input  1  grant from the arbiter for this device.
bus_data  output  N  head word; drives the tri-state buffer data input.
sent  output  1  one-cycle pulse in the cycle after each pop.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO is flushed and pointers are zeroed.
  - state=IDLE, req=0, count=0, empty=1, full=0, overflow=0, sent=0, bus_data=0, burst counter=0.
  - A reset mid-transfer drops req immediately and discards all queued words.
- bus_data:
  - Combinational read of mem[rd_ptr] when not empty.
  - N'b0 when empty.
- Push: on an edge with wr_en=1 and either not full or a pop in the same edge, wr_data is written at wr_ptr.
  - wr_en=1 while full and no pop: the word is dropped and overflow is set until reset.
- Pop: on an edge with state in {REQ, XFER}, grant=1 and not empty, rd_ptr advances.
  - grant while req=0 (IDLE/YIELD) is ignored.
- Simultaneous push and pop: both occur and count is unchanged. This applies when full and when count=1.
- Pointers wrap modulo DEPTH.
- count_next = count + push − pop.
- sent is registered: 1 in the cycle after each pop, otherwise 0.
- State machine (registered; req=1 in REQ and XFER only):
  - IDLE: if count>0, go to REQ; else stay.
  - REQ: grant=1 gives a pop with burst_cnt=1. Then:
    - count_next=0: go to IDLE.
    - burst limit reached: go to YIELD.
    - otherwise: go to XFER.
    - grant=0: stay.
  - XFER: grant=1 gives a pop with burst_cnt+1. Then:
    - count_next=0: go to IDLE.
    - burst_cnt+1 = MAX_BURST: go to YIELD.
    - grant=0 (pre-empted): go to REQ with burst_cnt=0.
  - YIELD: req=0 for exactly one cycle and burst_cnt=0. Then go to REQ if count_next>0, else IDLE.
- Latency:
  - Push to req high: 2 edges (count updates, then state goes IDLE→REQ).
  - Grant high to first pop: same edge.

Optional Feature:
BUS_TX_BURST_LIMIT_EN.
- Defined: the burst counter and YIELD state exist. The queue releases req for one cycle after MAX_BURST consecutive pops.
- Undefined:
  - No burst counter and no YIELD state; MAX_BURST is ignored.
  - The device holds req until the FIFO drains or grant is removed.

Test Plan:
- Reset mid-burst:
  - Stimulus: push 3 words, set grant=1, assert rst=0 after 1 pop.
  - Required: req=0 immediately, count=0, empty=1, bus_data=0.
- Basic transfer:
  - Stimulus: push 8'hA5 and 8'h3C, hold grant=1 from the first req.
  - Required: bus_data=A5 then 3C on consecutive cycles; sent pulses twice; req returns to 0 after 2 pops; empty=1.
- Full and overflow (DEPTH=4):
  - Stimulus: push 5 words with grant=0.
  - Required: full=1 after 4; the 5th is dropped; overflow=1; count=4.
  - Stimulus: then push and pop together.
  - Required: accepted, count stays 4, overflow stays 1.
- Burst limit (macro defined, MAX_BURST=2):
  - Stimulus: push 4 words, grant=1 continuously.
  - Required: pops 2, req=0 for one cycle, then pops 2 more.
  - Macro undefined: all 4 pop back-to-back with no req gap.
- Pre-emption:
  - Stimulus: push 3 words, grant=1 for 1 cycle, grant=0 for 3 cycles, grant=1 again.
  - Required: 1 pop; state returns to REQ with req held 1; remaining 2 pop later with correct order and no loss.
- Ignored grant:
  - Stimulus: grant=1 while empty and idle.
  - Required: no pop, sent=0, count=0, req=0.
